// File: rtl/alu_unit.sv
// 8-bit ALU with a single registered result/flag stage.
// F = {N, C, Z}; 16 operations selected by OP, one accepted per cycle.
module alu_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] OP,
  output logic [7:0] R,
  output logic [2:0] F
);

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpShl  = 4'b0010,
    OpShr  = 4'b0011,
    OpAnd  = 4'b0100,
    OpOr   = 4'b0101,
    OpXor  = 4'b0110,
    OpNot  = 4'b0111,
    OpInc  = 4'b1000,
    OpDec  = 4'b1001,
    OpRol  = 4'b1010,
    OpRor  = 4'b1011,
    OpAsr  = 4'b1100,
    OpPass = 4'b1101,
    OpNand = 4'b1110,
    OpCmp  = 4'b1111
  } op_e;

  op_e        op;
  logic [2:0] shamt;
  logic       shamt_nz;

  logic [8:0] sum;
  logic [8:0] diff;
  logic [8:0] inc;
  logic [8:0] dec;
  logic [8:0] shl_full;
  logic [8:0] shr_full;
  logic signed [8:0] asr_full;
  logic [7:0] rol;
  logic [7:0] ror;

  logic [7:0] res_d;
  logic       c_d;
  logic       z_d;
  logic       n_d;

  assign op       = op_e'(OP);
  assign shamt    = B[2:0];
  assign shamt_nz = (shamt != 3'd0);

  // Ninth bit of each 9-bit result is the carry/borrow out.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign inc  = {1'b0, A} + 9'd1;
  assign dec  = {1'b0, A} - 9'd1;

  // Extra bit on the outgoing side catches the last bit shifted out.
  assign shl_full = {1'b0, A} << shamt;
  assign shr_full = {A, 1'b0} >> shamt;
  assign asr_full = $signed({A, 1'b0}) >>> shamt;

  always_comb begin
    rol = '0;
    ror = '0;
    for (int i = 0; i < 8; i++) begin
      rol[i] = A[3'(i) - shamt];
      ror[i] = A[3'(i) + shamt];
    end
  end

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    unique case (op)
      OpAdd:  begin res_d = sum[7:0];      c_d = sum[8];  end
      OpSub:  begin res_d = diff[7:0];     c_d = diff[8]; end
      OpShl:  begin res_d = shl_full[7:0]; c_d = shl_full[8]; end
      OpShr:  begin res_d = shr_full[8:1]; c_d = shr_full[0]; end
      OpAnd:  res_d = A & B;
      OpOr:   res_d = A | B;
      OpXor:  res_d = A ^ B;
      OpNot:  res_d = ~A;
      OpInc:  begin res_d = inc[7:0];      c_d = inc[8];  end
      OpDec:  begin res_d = dec[7:0];      c_d = dec[8];  end
      // Rotate carry is the bit that wrapped last: it lands in R[0] or R[7].
      OpRol:  begin res_d = rol;           c_d = shamt_nz & rol[0]; end
      OpRor:  begin res_d = ror;           c_d = shamt_nz & ror[7]; end
      OpAsr:  begin res_d = asr_full[8:1]; c_d = asr_full[0]; end
      OpPass: res_d = B;
      OpNand: res_d = ~(A & B);
      OpCmp:  begin res_d = A;             c_d = diff[8]; end
      default: begin
        res_d = '0;
        c_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    z_d = (res_d == 8'h00);
    n_d = res_d[7];
    if (op == OpCmp) begin
      z_d = (diff[7:0] == 8'h00);
      n_d = diff[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= 8'h00;
      F <= 3'b000;
    end else begin
      R <= res_d;
      F <= {n_d, c_d, z_d};
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed boundary cases, reset behaviour and
// randomized operations against an integer-arithmetic reference model.
module tb_alu_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] OP;
  logic [7:0] R;
  logic [2:0] F;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic [2:0] f;
  } txn_t;

  txn_t exp_q[$];

  alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .OP    (OP),
    .R     (R),
    .F     (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    int ai = a;
    int bi = b;
    int n  = b % 8;
    int r  = 0;
    int c  = 0;
    int z;
    int ng;
    int t;
    case (op)
      4'h0: begin t = ai + bi; r = t % 256; c = (t > 255); end
      4'h1: begin r = (ai - bi + 256) % 256; c = (ai < bi); end
      4'h2: begin t = ai * (1 << n); r = t % 256; c = (n != 0) ? ((t >> 8) & 1) : 0; end
      4'h3: begin r = ai / (1 << n); c = (n != 0) ? ((ai >> (n - 1)) & 1) : 0; end
      4'h4: r = ai & bi;
      4'h5: r = ai | bi;
      4'h6: r = ai ^ bi;
      4'h7: r = 255 - ai;
      4'h8: begin r = (ai + 1) % 256; c = (ai == 255); end
      4'h9: begin r = (ai + 255) % 256; c = (ai == 0); end
      4'hA: begin
        r = ai;
        for (int k = 0; k < n; k++) begin c = (r >> 7) & 1; r = ((r << 1) | c) & 255; end
      end
      4'hB: begin
        r = ai;
        for (int k = 0; k < n; k++) begin c = r & 1; r = (r >> 1) | (c << 7); end
      end
      4'hC: begin
        r = ai;
        for (int k = 0; k < n; k++) begin c = r & 1; r = (r >> 1) | (r & 128); end
      end
      4'hD: r = bi;
      4'hE: r = 255 - (ai & bi);
      default: begin r = ai; c = (ai < bi); end
    endcase
    z  = (r == 0);
    ng = (r >= 128);
    if (op == 4'hF) begin
      t  = (ai - bi + 256) % 256;
      z  = (ai == bi);
      ng = (t >= 128);
    end
    return {r[7:0], ng[0], c[0], z[0]};
  endfunction

  task automatic check(input string name, input logic [7:0] r_act, input logic [2:0] f_act,
                       input logic [7:0] r_exp, input logic [2:0] f_exp);
    checks++;
    if (r_act !== r_exp || f_act !== f_exp) begin
      failures++;
      $display("FAIL %s: got R=%02h F=%03b, expected R=%02h F=%03b",
               name, r_act, f_act, r_exp, f_exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [10:0] m;
    @(negedge clk);
    A  = a;
    B  = b;
    OP = op;
    m  = model(a, b, op);
    exp_q.push_back('{a: a, b: b, op: op, r: m[10:3], f: m[2:0]});
  endtask

  // Monitor: every capture edge out of reset presents a result.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      txn_t t;
      string nm;
      t  = exp_q.pop_front();
      nm = $sformatf("op%01h a=%02h b=%02h", t.op, t.a, t.b);
      check(nm, R, F, t.r, t.f);
    end
  end

  task automatic drain();
    int budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    A     = 8'h00;
    B     = 8'h00;
    OP    = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", R, F, 8'h00, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with known results.
    issue(8'h0F, 8'h0F, 4'h0);  // R=1E F=000
    issue(8'h0F, 8'h0F, 4'h1);  // R=00 F=001
    issue(8'hFF, 8'h01, 4'h0);  // R=00 F=011
    issue(8'h00, 8'h01, 4'h1);  // R=FF F=110
    issue(8'hFF, 8'h00, 4'h8);  // INC wrap
    issue(8'h00, 8'h00, 4'h9);  // DEC wrap
    issue(8'h0F, 8'h03, 4'h2);  // R=78
    issue(8'h0F, 8'h03, 4'h4);  // R=03
    issue(8'h81, 8'h01, 4'hC);  // R=C0 F=110
    issue(8'h81, 8'h01, 4'hA);  // R=03 F=010
    issue(8'h81, 8'h08, 4'hA);  // amount 0
    issue(8'h81, 8'hF9, 4'hB);  // upper B bits ignored
    issue(8'h05, 8'h09, 4'hF);  // R=05 F=110
    issue(8'h42, 8'h42, 4'hF);  // F=001
    drain();

    // Constant expectations for the headline vectors, independent of the model.
    issue(8'h81, 8'h01, 4'hC);
    @(posedge clk);
    #2;
    check("asr_const", R, F, 8'hC0, 3'b110);

    // Output holds between edges while inputs change.
    issue(8'h0F, 8'h03, 4'h2);
    @(posedge clk);
    #2;
    A  = 8'hFF;
    B  = 8'hFF;
    OP = 4'h7;
    #2;
    check("hold", R, F, 8'h78, 3'b000);

    // Reset sequence: load, assert between edges, hold across edges, release.
    issue(8'h0F, 8'h0F, 4'h0);
    @(posedge clk);
    #2;
    check("load_1e", R, F, 8'h1E, 3'b000);
    A  = 8'h12;
    B  = 8'h34;
    OP = 4'h0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid", R, F, 8'h00, 3'b000);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", R, F, 8'h00, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    A     = 8'h20;
    B     = 8'h05;
    OP    = 4'h0;
    @(posedge clk);
    #2;
    check("reset_release", R, F, 8'h25, 3'b000);

    // Randomized operations against the model.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 4'($urandom_range(15, 0));
      if (k % 8 == 0) ra = (k % 16 == 0) ? 8'h00 : 8'hFF;
      issue(ra, rb, ro);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
